message_unpad: RTL and testbench

MESSAGE_UNPAD -- requirements
Module: message_unpad

---
 rtl/message_unpad.sv | 237 +++++++++++++++++++++++
 tb/tb_message_unpad.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_unpad.sv
// Strips canonical SHA-2 padding from a 512-bit block stream: emits message data words and the length.
// Optional padding/length checking is built when MESSAGE_UNPAD_CHECK_EN is defined.
module message_unpad (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync_rst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [511:0] data_out,
    output logic         data_out_last,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [63:0]  size_out,
    output logic         size_err,
    output logic         size_out_valid,
    input  logic         size_out_ready,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_TAIL, S_SIZE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [511:0]   r_h;
    logic           r_h_vld;
    logic [511:0]   r_t;
    logic           r_t_vld;
    logic [63:0]    r_len;
    logic [55:0]    r_cnt;
    logic [511:0]   r_dout;
    logic           r_dout_last;
    logic           r_dout_vld;
    logic [63:0]    r_size;
    logic           r_size_vld;

    logic           w_slot;
    logic           w_in_hs;
    logic [8:0]     w_rem;
    logic           w_extra;
    logic [511:0]   w_mask;
    logic           w_out_load;
    logic [511:0]   w_out_data;
    logic           w_out_last;
    logic           w_h_load;
    logic           w_h_clr;
    logic           w_t_load;
    logic           w_t_clr;
    logic           w_size_load;
    logic           w_size_done;

    // Every stream transfers a word on a rising edge where valid and ready are both high;
    // valid never drops without a transfer, and ready may depend combinationally on the sink.
    assign w_slot        = !r_dout_vld || data_out_ready;
    assign data_in_ready = nrst && !sync_rst && en &&
                           (r_state == S_EMPTY || r_state == S_HOLD) && w_slot;
    assign w_in_hs       = data_in_valid && data_in_ready;

    assign w_rem   = r_len[8:0];
    assign w_extra = (w_rem == 9'd0) || (w_rem >= 9'd448);
    assign w_mask  = (w_rem == 9'd0) ? {512{1'b1}} : ~({512{1'b1}} >> w_rem);

    always_comb begin
        w_state_nxt = r_state;
        w_out_load  = 1'b0;
        w_out_data  = r_h;
        w_out_last  = 1'b0;
        w_h_load    = 1'b0;
        w_h_clr     = 1'b0;
        w_t_load    = 1'b0;
        w_t_clr     = 1'b0;
        w_size_load = 1'b0;
        w_size_done = 1'b0;
        case (r_state)
            S_EMPTY, S_HOLD: begin
                if (w_in_hs) begin
                    if (data_in_last) begin
                        w_t_load    = 1'b1;
                        w_state_nxt = S_TAIL;
                    end else begin
                        w_h_load    = 1'b1;
                        w_out_load  = (r_state == S_HOLD);
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_TAIL: begin
                // When the final block carries no data, the held word is the last one.
                if (r_h_vld) begin
                    if (w_slot) begin
                        w_out_load = 1'b1;
                        w_out_data = w_extra ? (r_h & w_mask) : r_h;
                        w_out_last = w_extra;
                        w_h_clr    = 1'b1;
                        w_t_clr    = w_extra;
                    end
                end else if (r_t_vld) begin
                    if (w_extra) begin
                        w_t_clr = 1'b1;
                    end else if (w_slot) begin
                        w_out_load = 1'b1;
                        w_out_data = r_t & w_mask;
                        w_out_last = 1'b1;
                        w_t_clr    = 1'b1;
                    end
                end else if (w_slot) begin
                    w_size_load = 1'b1;
                    w_state_nxt = S_SIZE;
                end
            end
            S_SIZE: begin
                if (size_out_ready) begin
                    w_size_done = 1'b1;
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_EMPTY;
        end else if (sync_rst) begin
            r_state <= S_EMPTY;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

`ifdef MESSAGE_UNPAD_CHECK_EN
    logic           r_size_err;
    logic           w_high;
    logic [511:0]   w_mark_word;
    logic           w_marker;
    logic [511:0]   w_below;
    logic           w_fill_err;
    logic [65:0]    w_p;
    logic           w_err;

    // Marker sits in the held word when the data fills past bit 64 of its block.
    assign w_high      = (w_rem >= 9'd448);
    assign w_mark_word = w_high ? r_h : r_t;
    assign w_marker    = w_mark_word[9'd511 - w_rem];
    assign w_below     = {512{1'b1}} >> ({1'b0, w_rem} + 10'd1);
    assign w_fill_err  = w_high ? ((|(r_h & w_below)) || (|r_t[511:64]))
                                : (|(r_t & w_below & {{448{1'b1}}, 64'b0}));
    assign w_p         = ({2'b00, r_len} + 66'd576) >> 9;
    assign w_err       = !w_marker || w_fill_err || ({10'b0, r_cnt} != w_p);
    assign size_err    = r_size_err;
`else
    assign size_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_h         <= '0;
            r_h_vld     <= 1'b0;
            r_t         <= '0;
            r_t_vld     <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_size      <= '0;
            r_size_vld  <= 1'b0;
`ifdef MESSAGE_UNPAD_CHECK_EN
            r_size_err  <= 1'b0;
`endif
        end else if (sync_rst) begin
            r_h         <= '0;
            r_h_vld     <= 1'b0;
            r_t         <= '0;
            r_t_vld     <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_size      <= '0;
            r_size_vld  <= 1'b0;
`ifdef MESSAGE_UNPAD_CHECK_EN
            r_size_err  <= 1'b0;
`endif
        end else if (en) begin
            if (w_size_done) begin
                r_cnt <= '0;
            end else if (w_in_hs && (r_cnt != {56{1'b1}})) begin
                r_cnt <= r_cnt + 56'd1;
            end

            if (w_h_load) begin
                r_h     <= data_in;
                r_h_vld <= 1'b1;
            end else if (w_h_clr) begin
                r_h_vld <= 1'b0;
            end

            if (w_t_load) begin
                r_t     <= data_in;
                r_t_vld <= 1'b1;
                r_len   <= data_in[63:0];
            end else if (w_t_clr) begin
                r_t_vld <= 1'b0;
            end

            if (w_out_load) begin
                r_dout      <= w_out_data;
                r_dout_last <= w_out_last;
                r_dout_vld  <= 1'b1;
            end else if (data_out_ready) begin
                r_dout_vld  <= 1'b0;
            end

            if (w_size_load) begin
                r_size     <= r_len;
                r_size_vld <= 1'b1;
`ifdef MESSAGE_UNPAD_CHECK_EN
                r_size_err <= w_err;
`endif
            end else if (w_size_done) begin
                r_size_vld <= 1'b0;
            end
        end
    end

    assign data_out       = r_dout;
    assign data_out_last  = r_dout_last;
    assign data_out_valid = r_dout_vld;
    assign size_out       = r_size;
    assign size_out_valid = r_size_vld;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_message_unpad.sv
// Table-driven bench for message_unpad: padded messages of chosen lengths plus hand-written
// stall, enable, reset and malformed-length sequences; a negedge monitor scores every output.
module tb_message_unpad;

    logic         clk;
    logic         nrst;
    logic         en;
    logic         sync_rst;
    logic [511:0] data_in;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;
    logic [63:0]  size_out;
    logic         size_err;
    logic         size_out_valid;
    logic         size_out_ready;
    logic [1:0]   dbg_state;

`ifdef MESSAGE_UNPAD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [63:0] len;
        int          nblk;
        int          nwords;
        logic [1:0]  mode;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           rx_words = 0;
    logic [512:0] exp_q[$];
    logic [64:0]  exp_size_q[$];
    logic [511:0] msg_blk[4];
    logic [1:0]   rdy_mode;
    vec_t         vecs[12];

    message_unpad dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .sync_rst       (sync_rst),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .size_out       (size_out),
        .size_err       (size_err),
        .size_out_valid (size_out_valid),
        .size_out_ready (size_out_ready),
        .dbg_state      (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Sink ready pattern: 0 = always ready, 1 = random, 2 = left to the test sequence
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2'd0) begin
                data_out_ready = 1'b1;
                size_out_ready = 1'b1;
            end else if (rdy_mode == 2'd1) begin
                data_out_ready = 1'($urandom_range(0, 1));
                size_out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard monitor: a transfer seen at the negedge completes at the next posedge
    always @(negedge clk) begin
        if (nrst && !sync_rst && en) begin
            if (data_out_valid && data_out_ready) begin
                rx_words++;
                if (exp_q.size() == 0) check("pending_words", 0, 1);
                else check("data_word", {data_out_last, data_out}, exp_q.pop_front());
            end
            if (size_out_valid && size_out_ready) begin
                if (exp_size_q.size() == 0) check("pending_sizes", 0, 1);
                else check("size_word", {size_err, size_out}, exp_size_q.pop_front());
            end
        end
    end

    function automatic logic [511:0] pat(input int i, input logic [63:0] len);
        logic [511:0] r;
        if (len == 64'd24) return {24'h616263, 488'b0};
        for (int k = 0; k < 16; k++)
            r[k*32 +: 32] = 32'(32'h9E3779B9 * (i + 1)) ^ len[31:0] ^ 32'(32'h01000193 * k);
        return r;
    endfunction

    // Builds padded blocks into msg_blk and queues the expected words and size
    task automatic build_msg(input logic [63:0] len, input int nblk, input int nwords, input logic err);
        logic [511:0] w;
        rx_words = 0;
        for (int i = 0; i < 4; i++) msg_blk[i] = '0;
        for (int i = 0; i < nwords; i++) begin
            w = pat(i, len);
            for (int b = 0; b < 512; b++)
                if (longint'(i) * 512 + 511 - b >= longint'(len)) w[b] = 1'b0;
            msg_blk[i] = w;
            exp_q.push_back({(i == nwords - 1), w});
        end
        msg_blk[int'(len >> 9)][511 - int'(len[8:0])] = 1'b1;
        msg_blk[nblk-1][63:0] = msg_blk[nblk-1][63:0] | len;
        exp_size_q.push_back({err, len});
    endtask

    task automatic send_block(input logic [511:0] d, input logic l);
        int n;
        n = 0;
        data_in       = d;
        data_in_last  = l;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_accept", data_in_ready, 1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int nwords);
        int n;
        n = 0;
        while (exp_size_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("msg_done", exp_size_q.size(), 0);
        check("word_count", rx_words, nwords);
        check("words_left", exp_q.size(), 0);
        exp_q.delete();
        exp_size_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input logic [63:0] len, input int nblk, input int nwords);
        build_msg(len, nblk, nwords, 1'b0);
        for (int k = 0; k < nblk; k++) send_block(msg_blk[k], (k == nblk - 1));
        wait_done(nwords);
    endtask

    initial begin
        int           bad;
        logic [511:0] w;

        nrst = 1'b0; sync_rst = 1'b0; en = 1'b1;
        data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
        data_out_ready = 1'b1; size_out_ready = 1'b1; rdy_mode = 2'd2;

        vecs[0]  = '{64'd24,   1, 1, 2'd0};
        vecs[1]  = '{64'd0,    1, 0, 2'd0};
        vecs[2]  = '{64'd1,    1, 1, 2'd1};
        vecs[3]  = '{64'd447,  1, 1, 2'd0};
        vecs[4]  = '{64'd448,  2, 1, 2'd1};
        vecs[5]  = '{64'd511,  2, 1, 2'd0};
        vecs[6]  = '{64'd512,  2, 1, 2'd1};
        vecs[7]  = '{64'd513,  2, 2, 2'd0};
        vecs[8]  = '{64'd959,  2, 2, 2'd1};
        vecs[9]  = '{64'd960,  3, 2, 2'd0};
        vecs[10] = '{64'd1023, 3, 2, 2'd1};
        vecs[11] = '{64'd1536, 4, 3, 2'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", data_in_ready, 0);
        check("rst_out_valid", data_out_valid, 0);
        check("rst_size_valid", size_out_valid, 0);
        check("rst_dout", {data_out_last, data_out}, '0);
        check("rst_size", {size_err, size_out}, '0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", data_in_ready, 1);
        check("idle_state", dbg_state, 0);
        @(posedge clk);
        #1;

        // L=24 "abc": latency to first word and to size
        build_msg(64'd24, 1, 1, 1'b0);
        send_block(msg_blk[0], 1'b1);
        @(negedge clk);
        check("lat_tail_no_out", data_out_valid, 0);
        check("lat_tail_state", dbg_state, 2);
        @(negedge clk);
        check("lat_first_word", data_out_valid, 1);
        check("abc_word", {data_out_last, data_out}, {1'b1, 24'h616263, 488'b0});
        check("lat_no_size_yet", size_out_valid, 0);
        @(negedge clk);
        check("lat_size", size_out_valid, 1);
        wait_done(1);

        // Length table
        for (int v = 0; v < 12; v++) begin
            rdy_mode = vecs[v].mode;
            run_msg(vecs[v].len, vecs[v].nblk, vecs[v].nwords);
        end

        // L=1000 with the sink stalled for 10 cycles
        rdy_mode = 2'd2; data_out_ready = 1'b0; size_out_ready = 1'b1;
        build_msg(64'd1000, 3, 2, 1'b0);
        send_block(msg_blk[0], 1'b0);
        send_block(msg_blk[1], 1'b0);
        data_in = msg_blk[2]; data_in_last = 1'b1; data_in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_in_ready || !data_out_valid) bad++;
        end
        check("stall_in_ready", bad, 0);
        @(posedge clk);
        #1 data_out_ready = 1'b1;
        send_block(msg_blk[2], 1'b1);
        wait_done(2);

        // en=0 freezes a pending word
        build_msg(64'd24, 1, 1, 1'b0);
        send_block(msg_blk[0], 1'b1);
        @(posedge clk);
        #1 en = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!data_out_valid || data_out != {24'h616263, 488'b0} || data_in_ready || size_out_valid) bad++;
        end
        check("en_hold", bad, 0);
        @(posedge clk);
        #1 en = 1'b1;
        wait_done(1);

        // L=24 carried in two blocks: data path unchanged, size_err only in the checking build
        rdy_mode = 2'd0;
        rx_words = 0;
        w = {24'h616263, 1'b1, 487'b0};
        exp_q.push_back({1'b0, w});
        exp_q.push_back({1'b1, 512'b0});
        exp_size_q.push_back({CHK, 64'd24});
        send_block(w, 1'b0);
        send_block({448'b0, 64'd24}, 1'b1);
        wait_done(2);

        // Synchronous reset mid-message
        rdy_mode = 2'd2; data_out_ready = 1'b0;
        send_block({16{32'hDEADBEEF}}, 1'b0);
        send_block({16{32'hCAFEF00D}}, 1'b0);
        @(negedge clk);
        check("pre_srst_out_valid", data_out_valid, 1);
        @(posedge clk);
        #1 sync_rst = 1'b1;
        @(negedge clk);
        check("srst_in_ready", data_in_ready, 0);
        @(posedge clk);
        #1 sync_rst = 1'b0;
        @(negedge clk);
        check("srst_out_valid", data_out_valid, 0);
        check("srst_dout", data_out, '0);
        check("srst_size", {size_out_valid, size_out}, '0);
        check("srst_state", dbg_state, 0);
        @(posedge clk);
        #1 rdy_mode = 2'd0;
        run_msg(64'd513, 2, 2);

        // Asynchronous reset mid-message
        rdy_mode = 2'd2; data_out_ready = 1'b0;
        send_block({16{32'h12345678}}, 1'b0);
        send_block({16{32'h0F0F0F0F}}, 1'b0);
        #2 nrst = 1'b0;
        #1;
        check("nrst_out_valid", data_out_valid, 0);
        check("nrst_in_ready", data_in_ready, 0);
        check("nrst_state", dbg_state, 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        rdy_mode = 2'd0;
        run_msg(64'd1000, 3, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
